// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one 16-bit RAM port between the data path and the
//            instruction-cache line refill engine. Data accesses are
//            single-word reads or writes. Cache refills are 4-beat read
//            bursts that cannot be interrupted and are packed into a
//            64-bit line. A per-access timeout aborts a RAM access that
//            gets no acknowledge and sets a sticky error flag.
// Ports    :
//   clk, rst             clock, synchronous active-low reset
//   d_req/d_wri/d_addr/d_wdat  data request, direction, word address, data
//   d_rdat/d_wait/d_done       data read result, wait line, done pulse
//   c_req/c_addr               line refill request and line address
//   c_rdat/c_wait/c_done       filled line, wait line, done pulse
//   ram_addr/ram_wdat          RAM address and write data (registered)
//   ram_we/ram_re              RAM access strobes (registered)
//   ram_rdat/ram_ack           RAM read data and access acknowledge
//   bus_err                    sticky timeout flag
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  // data path requester
  input  logic        d_req,
  input  logic        d_wri,
  input  logic [31:0] d_addr,
  input  logic [15:0] d_wdat,
  output logic [15:0] d_rdat,
  output logic        d_wait,
  output logic        d_done,
  // cache refill requester
  input  logic        c_req,
  input  logic [31:0] c_addr,
  output logic [63:0] c_rdat,
  output logic        c_wait,
  output logic        c_done,
  // RAM port
  output logic [31:0] ram_addr,
  output logic [15:0] ram_wdat,
  output logic        ram_we,
  output logic        ram_re,
  input  logic [15:0] ram_rdat,
  input  logic        ram_ack,
  // status
  output logic        bus_err
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    D_ACC = 3'd1,
    C_ACC = 3'd2,
    C_GAP = 3'd3,
    TURN  = 3'd4
  } state_t;

  // The counter is compared before it increments, so hitting TIMEOUT-1 on
  // an un-acked edge means the strobe has been high for TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);
  localparam logic [15:0] FILL_WORD = 16'hFFFF;

  state_t      state;
  logic        last_grant;   // 0 = data served last, 1 = cache served last
  logic [1:0]  beat;         // current refill beat
  logic [15:0] tmo_cnt;

  logic        grant_d;
  logic        grant_c;
  logic        tmo_hit;
  logic        unused_caddr;

  // Tie-break: whoever was not served last wins. The decision only matters
  // in IDLE and is consumed by registers, so no request reaches ram_* in
  // the same cycle.
  assign grant_d = d_req & (~c_req | last_grant);
  assign grant_c = c_req & (~d_req | ~last_grant);

  assign tmo_hit = (tmo_cnt == TMO_LAST);

  assign d_wait = d_req & ~d_done;
  assign c_wait = c_req & ~c_done;

  // Line addresses are always refilled from word 0 of the line.
  assign unused_caddr = ^c_addr[1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;   // data wins the first tie
      beat       <= 2'd0;
      tmo_cnt    <= 16'd0;
      ram_addr   <= 32'd0;
      ram_wdat   <= 16'd0;
      ram_we     <= 1'b0;
      ram_re     <= 1'b0;
      d_rdat     <= 16'd0;
      c_rdat     <= 64'd0;
      d_done     <= 1'b0;
      c_done     <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            ram_addr   <= d_addr;
            ram_wdat   <= d_wdat;
            ram_we     <= d_wri;
            ram_re     <= ~d_wri;
            tmo_cnt    <= 16'd0;
            last_grant <= 1'b0;
            state      <= D_ACC;
          end else if (grant_c) begin
            ram_addr   <= {c_addr[31:2], 2'b00};
            ram_we     <= 1'b0;
            ram_re     <= 1'b1;
            beat       <= 2'd0;
            tmo_cnt    <= 16'd0;
            last_grant <= 1'b1;
            state      <= C_ACC;
          end
        end

        D_ACC: begin
          // An ack on the timeout edge still completes the access normally.
          if (ram_ack) begin
            ram_we <= 1'b0;
            ram_re <= 1'b0;
            if (ram_re) begin
              d_rdat <= ram_rdat;
            end
            d_done <= 1'b1;
            state  <= TURN;
          end else if (tmo_hit) begin
            ram_we  <= 1'b0;
            ram_re  <= 1'b0;
            if (ram_re) begin
              d_rdat <= FILL_WORD;
            end
            bus_err <= 1'b1;
            d_done  <= 1'b1;
            state   <= TURN;
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        C_ACC: begin
          if (ram_ack) begin
            c_rdat[{beat, 4'b0000} +: 16] <= ram_rdat;
            ram_re <= 1'b0;
            if (beat == 2'd3) begin
              c_done <= 1'b1;
              state  <= TURN;
            end else begin
              beat  <= beat + 2'd1;
              state <= C_GAP;
            end
          end else if (tmo_hit) begin
            // Abandon the rest of the burst; the current beat and every
            // later word of the line read as all ones.
            ram_re  <= 1'b0;
            bus_err <= 1'b1;
            c_done  <= 1'b1;
            state   <= TURN;
            for (int i = 0; i < 4; i++) begin
              if (i >= int'(beat)) begin
                c_rdat[16*i +: 16] <= FILL_WORD;
              end
            end
          end else begin
            tmo_cnt <= tmo_cnt + 16'd1;
          end
        end

        C_GAP: begin
          // beat already points at the next word; the upper address bits
          // were latched at grant and stay put for the whole burst.
          ram_addr[1:0] <= beat;
          ram_re        <= 1'b1;
          tmo_cnt       <= 16'd0;
          state         <= C_ACC;
        end

        TURN: begin
          d_done <= 1'b0;
          c_done <= 1'b0;
          state  <= IDLE;
        end

        default: begin
          ram_we <= 1'b0;
          ram_re <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. A behavioural RAM
//            answers each strobe after a chosen number of wait cycles and
//            logs every access; a transaction-level model predicts grant
//            order, completion cycles, read data, filled lines, error flag
//            and the RAM access list.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_wri;
  logic [31:0] d_addr;
  logic [15:0] d_wdat;
  logic [15:0] d_rdat;
  logic        d_wait, d_done;
  logic        c_req;
  logic [31:0] c_addr;
  logic [63:0] c_rdat;
  logic        c_wait, c_done;
  logic [31:0] ram_addr;
  logic [15:0] ram_wdat;
  logic        ram_we, ram_re;
  logic [15:0] ram_rdat;
  logic        ram_ack;
  logic        bus_err;

  mem_port_arbiter #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .d_req(d_req), .d_wri(d_wri), .d_addr(d_addr), .d_wdat(d_wdat),
    .d_rdat(d_rdat), .d_wait(d_wait), .d_done(d_done),
    .c_req(c_req), .c_addr(c_addr), .c_rdat(c_rdat),
    .c_wait(c_wait), .c_done(c_done),
    .ram_addr(ram_addr), .ram_wdat(ram_wdat), .ram_we(ram_we), .ram_re(ram_re),
    .ram_rdat(ram_rdat), .ram_ack(ram_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // RAM environment state
  int          wait_q[$];
  logic [48:0] log_q[$];
  int          len_q[$];
  int          scnt = 0;
  int          cur_wait = 0;
  logic [48:0] s_snap;
  bit          spur = 1'b0;
  logic [15:0] ram_mem [logic [31:0]];

  // reference model state
  logic [15:0] exp_mem [logic [31:0]];
  bit          m_last = 1'b1;
  bit          m_err = 1'b0;
  logic [15:0] m_drdat = 16'd0;
  logic [63:0] m_crdat = 64'd0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Power-on RAM contents: line 0x40 holds 1111..4444, elsewhere a hash.
  function automatic logic [15:0] ram_init(input logic [31:0] a);
    if (a[31:2] == 30'h10) return 16'h1111 * (16'(a[1:0]) + 16'd1);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] mem_rd(input logic [31:0] a);
    return ram_mem.exists(a) ? ram_mem[a] : ram_init(a);
  endfunction

  function automatic logic [15:0] exp_rd(input logic [31:0] a);
    return exp_mem.exists(a) ? exp_mem[a] : ram_init(a);
  endfunction

  // Behavioural RAM, evaluated once per cycle at the falling edge.
  task automatic respond();
    if (ram_we || ram_re) begin
      chk("strobe_excl", 64'(ram_we & ram_re), 64'd0);
      if (scnt == 0) begin
        cur_wait = (wait_q.size() > 0) ? wait_q.pop_front() : 0;
        s_snap   = {ram_we, ram_addr, ram_wdat};
        log_q.push_back({ram_we, ram_addr, ram_we ? ram_wdat : 16'h0});
      end else begin
        chk("ram_hold", 64'({ram_we, ram_addr, ram_wdat}), 64'(s_snap));
      end
      ram_ack  = (scnt == cur_wait);
      ram_rdat = ram_ack ? mem_rd(ram_addr) : 16'($urandom);
      if (ram_ack && ram_we) ram_mem[ram_addr] = ram_wdat;
      scnt++;
    end else begin
      if (scnt > 0) len_q.push_back(scnt);
      scnt     = 0;
      ram_ack  = spur;
      ram_rdat = 16'($urandom);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
    @(posedge clk);
    #1;
  endtask

  function automatic int rw();
    int w;
    w = int'($urandom_range(0, 9));
    return (w > 5) ? 0 : w;
  endfunction

  // One transaction group: optional data access, optional refill, data
  // request either together with the refill or d_late cycles after it.
  task automatic run(input bit do_d, input bit dwri, input logic [31:0] daddr,
                     input logic [15:0] dwdat, input bit do_c, input logic [31:0] caddr,
                     input int d_late, input int dw,
                     input int cw0, input int cw1, input int cw2, input int cw3);
    int          cw[4];
    bit          c_first, pend_d, pend_c, ab;
    int          lat_d, lat_c, t_d, t_c, t, nb, l;
    logic [15:0] e_d;
    logic [63:0] e_c;
    bit          e_err_d, e_err_c;
    logic [48:0] e_log[$];
    int          e_len[$];
    logic [31:0] a;
    cw[0] = cw0; cw[1] = cw1; cw[2] = cw2; cw[3] = cw3;
    log_q.delete(); len_q.delete(); wait_q.delete();
    e_err_d = 1'b0; e_err_c = 1'b0; lat_d = 0; lat_c = 0;
    // tie goes to whoever was not served last
    c_first = do_c && (!do_d || d_late > 0 || !m_last);
    e_d = m_drdat;
    e_c = m_crdat;
    for (int p = 0; p < 2; p++) begin
      if (do_c && ((p == 0) == c_first)) begin
        nb = 0; ab = 1'b0;
        for (int k = 0; k < 4; k++) begin
          if (!ab) begin
            a = {caddr[31:2], 2'(k)};
            l = (cw[k] + 1 < TMO) ? cw[k] + 1 : TMO;
            lat_c += l; nb++;
            e_len.push_back(l);
            e_log.push_back({1'b0, a, 16'h0});
            wait_q.push_back(cw[k]);
            if (cw[k] >= TMO) begin
              ab = 1'b1;
              for (int j = k; j < 4; j++) e_c[16*j +: 16] = 16'hFFFF;
            end else begin
              e_c[16*k +: 16] = exp_rd(a);
            end
          end
        end
        lat_c += nb;  // one strobe-low cycle after every beat (gaps + done)
        m_err   = m_err | ab;
        e_err_c = m_err;
        m_last  = 1'b1;
        m_crdat = e_c;
      end
      if (do_d && ((p == 0) != c_first)) begin
        l  = (dw + 1 < TMO) ? dw + 1 : TMO;
        ab = (dw >= TMO);
        lat_d = l + 1;
        e_len.push_back(l);
        e_log.push_back({dwri, daddr, dwri ? dwdat : 16'h0});
        wait_q.push_back(dw);
        if (!dwri) e_d = ab ? 16'hFFFF : exp_rd(daddr);
        else if (!ab) exp_mem[daddr] = dwdat;
        m_err   = m_err | ab;
        e_err_d = m_err;
        m_last  = 1'b0;
        m_drdat = e_d;
      end
    end
    if (c_first) begin t_c = lat_c; t_d = lat_c + 1 + lat_d; end
    else begin t_d = lat_d; t_c = lat_d + 1 + lat_c; end

    d_wri = dwri; d_addr = daddr; d_wdat = dwdat; c_addr = caddr;
    c_req = do_c;
    d_req = do_d && (d_late == 0);
    pend_d = do_d; pend_c = do_c; t = 0;
    while ((pend_d || pend_c) && t < 300) begin
      tick();
      t++;
      if (d_req) chk("d_wait", 64'(d_wait), 64'(t != t_d));
      if (c_req) chk("c_wait", 64'(c_wait), 64'(t != t_c));
      if (d_done) begin
        if (pend_d) begin
          chk("d_done_cycle", 64'(t), 64'(t_d));
          chk("d_rdat", 64'(d_rdat), 64'(e_d));
          chk("bus_err_d", 64'(bus_err), 64'(e_err_d));
          pend_d = 1'b0;
          d_req  = 1'b0;
        end else begin
          chk("d_done_extra", 64'(d_done), 64'd0);
        end
      end
      if (c_done) begin
        if (pend_c) begin
          chk("c_done_cycle", 64'(t), 64'(t_c));
          chk("c_rdat", c_rdat, e_c);
          chk("bus_err_c", 64'(bus_err), 64'(e_err_c));
          pend_c = 1'b0;
          c_req  = 1'b0;
        end else begin
          chk("c_done_extra", 64'(c_done), 64'd0);
        end
      end
      if (do_d && d_late > 0 && t == d_late) d_req = 1'b1;
    end
    chk("d_pending", 64'(pend_d), 64'd0);
    chk("c_pending", 64'(pend_c), 64'd0);
    tick();
    chk("idle_after", 64'({ram_we, ram_re, d_done, c_done}), 64'd0);
    chk("n_access", 64'(log_q.size()), 64'(e_log.size()));
    for (int i = 0; i < e_log.size() && i < log_q.size(); i++)
      chk("access", 64'(log_q[i]), 64'(e_log[i]));
    chk("n_strobe_len", 64'(len_q.size()), 64'(e_len.size()));
    for (int i = 0; i < e_len.size() && i < len_q.size(); i++)
      chk("strobe_len", 64'(len_q[i]), 64'(e_len[i]));
  endtask

  initial begin
    int kind;
    bit found;
    rst = 1'b0; d_req = 1'b0; d_wri = 1'b0; d_addr = 32'd0; d_wdat = 16'd0;
    c_req = 1'b0; c_addr = 32'd0; ram_ack = 1'b0; ram_rdat = 16'd0;
    repeat (3) tick();
    chk("rst_regs", {ram_addr, ram_wdat, d_rdat}, 64'd0);
    chk("rst_line", c_rdat, 64'd0);
    chk("rst_flags", 64'({ram_we, ram_re, d_done, c_done, bus_err, d_wait, c_wait}), 64'd0);
    rst = 1'b1;
    tick();

    // simultaneous requests after reset: data wins the first tie
    run(1, 0, 32'h100, 16'h0, 1, 32'h104, 0, 0, 0, 0, 0, 0);
    chk("tie_first_is_data", 64'(log_q[0][47:16]), 64'h100);
    run(1, 1, 32'h101, 16'h1357, 1, 32'h108, 0, 1, 0, 1, 0, 0);
    run(1, 0, 32'h101, 16'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    run(1, 0, 32'h102, 16'h0, 1, 32'h10C, 0, 0, 2, 0, 0, 1);

    // data write with two RAM wait cycles, then read it back
    run(1, 1, 32'h0000_1234, 16'hBEEF, 0, 32'h0, 0, 2, 0, 0, 0, 0);
    chk("wr_strobe_cycles", 64'(len_q[0]), 64'd3);
    run(1, 0, 32'h0000_1234, 16'h0, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    chk("rd_back", 64'(d_rdat), 64'hBEEF);

    // zero-wait line refill of line 0x40
    run(0, 0, 32'h0, 16'h0, 1, 32'h0000_0043, 0, 0, 0, 0, 0, 0);
    chk("line_43", c_rdat, 64'h4444_3333_2222_1111);

    // data request raised in the middle of a burst
    run(1, 0, 32'h0000_1234, 16'h0, 1, 32'h48, 2, 0, 0, 1, 0, 0);

    // timeouts: data read, good write afterwards, aborted burst
    run(1, 0, 32'h300, 16'h0, 0, 32'h0, 0, 1000, 0, 0, 0, 0);
    chk("tmo_rdat", 64'(d_rdat), 64'hFFFF);
    chk("tmo_err", 64'(bus_err), 64'd1);
    run(1, 1, 32'h301, 16'hA5A5, 0, 32'h0, 0, 0, 0, 0, 0, 0);
    run(0, 0, 32'h0, 16'h0, 1, 32'h310, 0, 0, 0, 0, 1000, 0);
    run(1, 0, 32'h301, 16'h0, 0, 32'h0, 0, 3, 0, 0, 0, 0);

    // spurious acknowledges in IDLE, C_GAP and TURN are ignored
    spur = 1'b1;
    repeat (3) tick();
    chk("spur_idle_line", c_rdat, m_crdat);
    chk("spur_idle_flags", 64'({ram_we, ram_re, d_done, c_done}), 64'd0);
    run(0, 0, 32'h0, 16'h0, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    spur = 1'b0;

    // randomized traffic
    for (int it = 0; it < 40; it++) begin
      kind = int'($urandom_range(0, 3));
      run(kind != 1, 1'($urandom), 32'h100 + 32'($urandom_range(0, 15)), 16'($urandom),
          kind != 0, 32'h100 + 32'($urandom_range(0, 15)),
          (kind == 3) ? int'($urandom_range(1, 3)) : 0,
          rw(), rw(), rw(), rw(), rw());
    end

    // reset in the middle of beat 2 of a refill
    wait_q.delete();
    wait_q.push_back(0); wait_q.push_back(0); wait_q.push_back(50);
    c_addr = 32'h208; c_req = 1'b1; found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      tick();
      if (ram_re && ram_addr[1:0] == 2'd2) found = 1'b1;
    end
    chk("beat2_seen", 64'(found), 64'd1);
    rst = 1'b0;
    tick();
    chk("rst_burst_flags", 64'({ram_we, ram_re, c_done, d_done, bus_err}), 64'd0);
    chk("rst_burst_line", c_rdat, 64'd0);
    chk("rst_burst_regs", {ram_addr, ram_wdat, d_rdat}, 64'd0);
    tick();
    rst = 1'b1;
    m_last = 1'b1; m_err = 1'b0; m_drdat = 16'd0; m_crdat = 64'd0;
    run(0, 0, 32'h0, 16'h0, 1, 32'h208, 0, 0, 0, 0, 1, 0);
    run(1, 0, 32'h105, 16'h0, 1, 32'h20C, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
